// File: rtl/regc_arbiter_pkg.sv
// rtl/regc_arbiter_pkg.sv - shared state encodings and widths for the register-C arbiter
package regc_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int GAP_W  = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin winner select, purely combinational
module rr_arb2 (
    input  logic reqA,
    input  logic reqB,
    input  logic lastSrc,
    output logic grantA,
    output logic grantB
);

    // On contention the requester that did not win last time takes the grant.
    assign grantA = reqA & (~reqB | lastSrc);
    assign grantB = reqB & (~reqA | ~lastSrc);

endmodule

// File: rtl/regc_arbiter.sv
// rtl/regc_arbiter.sv - arbitrates two writers onto register C with a configurable idle gap
module regc_arbiter
    import regc_arbiter_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reqA,
    input  logic [DATA_W-1:0] dataA,
    output logic              ackA,
    input  logic              reqB,
    input  logic [DATA_W-1:0] dataB,
    output logic              ackB,
    output logic              loadC,
    output logic [DATA_W-1:0] dataCin,
    output logic              busy,
    output logic              lastSrc,
    output logic [CNT_W-1:0]  loadCnt
);

    localparam logic [GAP_W-1:0] GAP_LAST =
        (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    state_e              state_q, state_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                win_q, win_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                load_q, load_d;
    logic                ack_a_q, ack_a_d;
    logic                ack_b_q, ack_b_d;
    logic                busy_q, busy_d;
    logic                last_src_q, last_src_d;
    logic [CNT_W-1:0]    load_cnt_q, load_cnt_d;

    logic                grant_a;
    logic                grant_b;

    // win_q tracks the arbitration decision immediately so back-to-back grants
    // alternate even though lastSrc only updates once the load completes.
    rr_arb2 u_rr_arb2 (
        .reqA    (reqA),
        .reqB    (reqB),
        .lastSrc (win_q),
        .grantA  (grant_a),
        .grantB  (grant_b)
    );

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        win_d     = win_q;
        data_d    = data_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_a || grant_b) begin
                    state_d = ST_LOAD;
                    win_d   = grant_b ? SRC_B : SRC_A;
                    data_d  = grant_b ? dataB : dataA;
                end
            end
            ST_LOAD: begin
                gap_cnt_d = '0;
                state_d   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                gap_cnt_d = '0;
            end
        endcase

        // Strobes trail the LOAD state by one register stage.
        load_d  = (state_q == ST_LOAD);
        ack_a_d = (state_q == ST_LOAD) && (win_q == SRC_A);
        ack_b_d = (state_q == ST_LOAD) && (win_q == SRC_B);
        busy_d  = (state_d != ST_IDLE);

        last_src_d = last_src_q;
        load_cnt_d = load_cnt_q;
        if (load_q) begin
            last_src_d = ack_b_q;
            load_cnt_d = load_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gap_cnt_q  <= '0;
            win_q      <= SRC_B;
            data_q     <= '0;
            load_q     <= 1'b0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            busy_q     <= 1'b0;
            last_src_q <= SRC_B;
            load_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            win_q      <= win_d;
            data_q     <= data_d;
            load_q     <= load_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            busy_q     <= busy_d;
            last_src_q <= last_src_d;
            load_cnt_q <= load_cnt_d;
        end
    end

    assign ackA    = ack_a_q;
    assign ackB    = ack_b_q;
    assign loadC   = load_q;
    assign dataCin = data_q;
    assign busy    = busy_q;
    assign lastSrc = last_src_q;
    assign loadCnt = load_cnt_q;

endmodule

// File: tb/tb_regc_arbiter.sv
// tb/tb_regc_arbiter.sv - directed bench for regc_arbiter with GAP_CYCLES of 1 and 0
module tb_regc_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with a one-cycle gap
    logic        rst1 = 1'b1, req_a1 = 1'b0, req_b1 = 1'b0;
    logic [31:0] data_a1 = '0, data_b1 = '0;
    logic        ack_a1, ack_b1, load_c1, busy1, last_src1;
    logic [31:0] data_cin1;
    logic [7:0]  load_cnt1;
    logic [31:0] data_cout1;

    // Instance with no gap
    logic        rst0 = 1'b1, req_a0 = 1'b0, req_b0 = 1'b0;
    logic [31:0] data_a0 = '0, data_b0 = '0;
    logic        ack_a0, ack_b0, load_c0, busy0, last_src0;
    logic [31:0] data_cin0;
    logic [7:0]  load_cnt0;

    int n_vec = 0;
    int n_err = 0;

    regc_arbiter #(.GAP_CYCLES(1)) u_dut_g1 (
        .clk(clk), .rst(rst1),
        .reqA(req_a1), .dataA(data_a1), .ackA(ack_a1),
        .reqB(req_b1), .dataB(data_b1), .ackB(ack_b1),
        .loadC(load_c1), .dataCin(data_cin1), .busy(busy1),
        .lastSrc(last_src1), .loadCnt(load_cnt1)
    );

    regc_arbiter #(.GAP_CYCLES(0)) u_dut_g0 (
        .clk(clk), .rst(rst0),
        .reqA(req_a0), .dataA(data_a0), .ackA(ack_a0),
        .reqB(req_b0), .dataB(data_b0), .ackB(ack_b0),
        .loadC(load_c0), .dataCin(data_cin0), .busy(busy0),
        .lastSrc(last_src0), .loadCnt(load_cnt0)
    );

    // Register C fed by the arbiter
    always @(posedge clk) begin
        if (rst1)         data_cout1 <= 32'h0;
        else if (load_c1) data_cout1 <= data_cin1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_loadC",   32'(load_c1),   32'd0);
        chk("rst_ackA",    32'(ack_a1),    32'd0);
        chk("rst_ackB",    32'(ack_b1),    32'd0);
        chk("rst_dataCin", data_cin1,      32'h0);
        chk("rst_busy",    32'(busy1),     32'd0);
        chk("rst_lastSrc", 32'(last_src1), 32'd1);
        chk("rst_loadCnt", 32'(load_cnt1), 32'd0);

        // Single A request, present as reset releases
        rst1 = 1'b0; req_a1 = 1'b1; data_a1 = 32'h00f430fe;
        tick();
        chk("a1_busy_load",  32'(busy1),   32'd1);
        chk("a1_loadC_early", 32'(load_c1), 32'd0);
        tick();
        chk("a1_loadC",   32'(load_c1), 32'd1);
        chk("a1_ackA",    32'(ack_a1),  32'd1);
        chk("a1_ackB",    32'(ack_b1),  32'd0);
        chk("a1_dataCin", data_cin1,    32'h00f430fe);
        chk("a1_busy_gap", 32'(busy1),  32'd1);
        req_a1 = 1'b0;
        tick();
        chk("a1_dataCout", data_cout1,     32'h00f430fe);
        chk("a1_loadCnt",  32'(load_cnt1), 32'd1);
        chk("a1_lastSrc",  32'(last_src1), 32'd0);
        chk("a1_loadC_off", 32'(load_c1),  32'd0);
        chk("a1_hold",     data_cin1,      32'h00f430fe);

        // Simultaneous A and B after reset: A first, B three cycles later
        rst1 = 1'b1; tick(); rst1 = 1'b0;
        req_a1 = 1'b1; data_a1 = 32'h00f430fe;
        req_b1 = 1'b1; data_b1 = 32'h12340fe6;
        tick(); tick();
        chk("ab_ackA",    32'(ack_a1),  32'd1);
        chk("ab_ackB0",   32'(ack_b1),  32'd0);
        chk("ab_dataA",   data_cin1,    32'h00f430fe);
        req_a1 = 1'b0;
        tick();
        chk("ab_gap_loadC", 32'(load_c1), 32'd0);
        tick();
        chk("ab_idle_loadC", 32'(load_c1), 32'd0);
        tick();
        chk("ab_loadC_b", 32'(load_c1), 32'd1);
        chk("ab_ackB",    32'(ack_b1),  32'd1);
        chk("ab_ackA0",   32'(ack_a1),  32'd0);
        chk("ab_dataB",   data_cin1,    32'h12340fe6);
        req_b1 = 1'b0;
        tick();
        chk("ab_lastSrc", 32'(last_src1), 32'd1);
        chk("ab_loadCnt", 32'(load_cnt1), 32'd2);
        chk("ab_dataCout", data_cout1,    32'h12340fe6);

        // Reset landing on the load cycle of a B request
        tick();
        req_b1 = 1'b1; data_b1 = 32'hdeadbeef;
        tick(); tick();
        chk("rl_loadC_pre", 32'(load_c1), 32'd1);
        chk("rl_ackB_pre",  32'(ack_b1),  32'd1);
        rst1 = 1'b1; req_b1 = 1'b0;
        tick();
        rst1 = 1'b0;
        chk("rl_loadC",   32'(load_c1),   32'd0);
        chk("rl_ackB",    32'(ack_b1),    32'd0);
        chk("rl_dataCin", data_cin1,      32'h0);
        chk("rl_loadCnt", 32'(load_cnt1), 32'd0);
        chk("rl_lastSrc", 32'(last_src1), 32'd1);
        tick();
        chk("rl_ackB_again", 32'(ack_b1),    32'd0);
        chk("rl_cnt_again",  32'(load_cnt1), 32'd0);

        // One-cycle B pulse during GAP is ignored
        req_a1 = 1'b1; data_a1 = 32'h0000a5a5;
        tick(); tick();
        chk("gp_ackA", 32'(ack_a1), 32'd1);
        req_a1 = 1'b0; req_b1 = 1'b1; data_b1 = 32'h0000b0b0;
        tick();
        req_b1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("gp_ackB_%0d", i),  32'(ack_b1),  32'd0);
            chk($sformatf("gp_loadC_%0d", i), 32'(load_c1), 32'd0);
        end
        chk("gp_loadCnt", 32'(load_cnt1), 32'd1);
        chk("gp_dataCin", data_cin1,      32'h0000a5a5);

        // GAP_CYCLES=0: A held for 256 grants, loads every two cycles, count wraps
        rst0 = 1'b0; req_a0 = 1'b1; data_a0 = 32'h00000077;
        tick();
        for (int n = 1; n <= 256; n++) begin
            tick();
            chk($sformatf("wr_loadC_hi_%0d", n), 32'(load_c0), 32'd1);
            tick();
            chk($sformatf("wr_loadC_lo_%0d", n), 32'(load_c0), 32'd0);
            if (n == 1)   chk("wr_cnt_1",   32'(load_cnt0), 32'd1);
            if (n == 255) chk("wr_cnt_255", 32'(load_cnt0), 32'd255);
            if (n == 256) chk("wr_cnt_0",   32'(load_cnt0), 32'd0);
        end
        req_a0 = 1'b0;

        // Both held: acks alternate A, B, A, B, A, B
        rst0 = 1'b1; tick(); rst0 = 1'b0;
        req_a0 = 1'b1; req_b0 = 1'b1; data_a0 = 32'h1; data_b0 = 32'h2;
        tick();
        for (int g = 0; g < 6; g++) begin
            tick();
            chk($sformatf("rr_ackA_%0d", g), 32'(ack_a0), 32'((g % 2) == 0));
            chk($sformatf("rr_ackB_%0d", g), 32'(ack_b0), 32'((g % 2) == 1));
            chk($sformatf("rr_data_%0d", g), data_cin0, ((g % 2) == 0) ? 32'h1 : 32'h2);
            tick();
            chk($sformatf("rr_noack_%0d", g), 32'(ack_a0 | ack_b0), 32'd0);
        end
        req_a0 = 1'b0; req_b0 = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
